// File: rtl/jtag_vpi_driver_pkg.sv
// jtag_vpi_driver shared types.
// Command opcodes, reset length and FSM states.
package jtag_vpi_pkg;

  typedef enum logic [1:0] {
    OP_RESET     = 2'd0,
    OP_TMS_SEQ   = 2'd1,
    OP_SCAN      = 2'd2,
    OP_SCAN_FLIP = 2'd3
  } op_e;

  localparam int unsigned RESET_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/jtag_vpi_driver_if.sv
// jtag_vpi_driver command/response bus.
// master = host command source, slave = driver.
interface jtag_vpi_driver_if #(
  parameter int DATA_W = 32
);
  localparam int LW = $clog2(DATA_W) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [LW-1:0]     cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/jtag_vpi_driver_tck_gen.sv
// TCK generator: TCK_DIV-cycle half periods while running.
// rise/fall strobes mark the edge on which tck toggles.
module jtag_vpi_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic rise_o,
  output logic fall_o,
  output logic tck_o
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          flip;

  // half-period counter; idle forces tck low and restarts the count
  always_comb begin
    flip  = run_i && (cnt_q == CW'(TCK_DIV - 1));
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!run_i) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (flip) begin
      cnt_d = '0;
      tck_d = !tck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter and tck registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign rise_o = flip && !tck_q;
  assign fall_o = flip && tck_q;
  assign tck_o  = tck_q;

endmodule

// File: rtl/jtag_vpi_driver.sv
// JTAG master: bit-level RESET / TMS_SEQ / SCAN commands.
// Define JTAG_VPI_FLIP_TMS_EN to raise tms on the last bit of op 3.
module jtag_vpi_driver
  import jtag_vpi_pkg::*;
#(
  parameter int TCK_DIV = 2,
  parameter int DATA_W  = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable,
  input  logic init_done,
  output logic tms,
  output logic tck,
  output logic tdi,
  input  logic tdo,
  jtag_vpi_driver_if.slave bus
);

  localparam int LW = $clog2(DATA_W) + 1;
  localparam int IW = $clog2(DATA_W);

`ifdef JTAG_VPI_FLIP_TMS_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              tck_rise, tck_fall, tck_run;
  logic              accept;
  op_e               cmd_op;
  logic [IW-1:0]     cmd_last;
  logic [IW-1:0]     idx_nx;

  // returns {tms, tdi} for one bit of the given op
  function automatic logic [1:0] drive_bit(
    op_e  op,
    logic d,
    logic is_last
  );
    logic [1:0] tt;
    tt = 2'b10;
    unique case (op)
      OP_RESET:     tt = 2'b10;
      OP_TMS_SEQ:   tt = {d, 1'b0};
      OP_SCAN:      tt = {1'b0, d};
      OP_SCAN_FLIP: tt = {FLIP_EN & is_last, d};
    endcase
    return tt;
  endfunction

  jtag_vpi_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (tck_run),
    .rise_o (tck_rise),
    .fall_o (tck_fall),
    .tck_o  (tck)
  );

  assign tck_run = (state_q != ST_IDLE);
  assign accept  = bus.cmd_valid && cmd_ready_q;
  assign idx_nx  = idx_q + IW'(1);

  // last bit index of the incoming command; len 0 runs one bit
  always_comb begin
    cmd_op = op_e'(bus.cmd_op);
    if (cmd_op == OP_RESET) begin
      cmd_last = IW'(RESET_BITS - 1);
    end else if (bus.cmd_len == '0) begin
      cmd_last = '0;
    end else if (bus.cmd_len > LW'(DATA_W)) begin
      cmd_last = IW'(DATA_W - 1);
    end else begin
      cmd_last = IW'(bus.cmd_len - LW'(1));
    end
  end

  // FSM next state: accept, sample tdo on rise, shift on fall
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    last_d      = last_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = enable && init_done;
        if (accept) begin
          state_d        = ST_LOW;
          op_d           = cmd_op;
          idx_d          = '0;
          last_d         = cmd_last;
          data_d         = bus.cmd_data;
          cap_d          = '0;
          cmd_ready_d    = 1'b0;
          {tms_d, tdi_d} = drive_bit(cmd_op,
                                     bus.cmd_data[0],
                                     cmd_last == '0);
        end
      end
      ST_LOW: begin
        if (tck_rise) begin
          cap_d[idx_q] = tdo;
          state_d      = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (tck_fall) begin
          if (idx_q == last_q) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = cap_q;
            cmd_ready_d = enable && init_done;
          end else begin
            idx_d          = idx_nx;
            state_d        = ST_LOW;
            {tms_d, tdi_d} = drive_bit(op_q,
                                       data_q[idx_nx],
                                       idx_nx == last_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      idx_q       <= '0;
      last_q      <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_vpi_driver.sv
// Bench for jtag_vpi_driver: vector table + scoreboard,
// plus hand sequences for gating, back-to-back and reset.
module tb_jtag_vpi_driver;
  import jtag_vpi_pkg::*;

  localparam int D  = 2;
  localparam int DW = 32;
  localparam int LW = $clog2(DW) + 1;

`ifdef JTAG_VPI_FLIP_TMS_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic enable = 1'b1;
  logic init_done = 1'b1;
  logic tdo = 1'b0;
  logic tms, tck, tdi;

  jtag_vpi_driver_if #(.DATA_W(DW)) bus ();

  jtag_vpi_driver #(
    .TCK_DIV (D),
    .DATA_W  (DW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .enable    (enable),
    .init_done (init_done),
    .tms       (tms),
    .tck       (tck),
    .tdi       (tdi),
    .tdo       (tdo),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [31:0] data;
    logic [31:0] pat;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] etms;
    logic [31:0] etdi;
    int          n;
    int          acc;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ri = 0;
  logic [31:0] obs_tms = '0;
  logic [31:0] obs_tdi = '0;
  logic [31:0] cur_pat = '0;
  int          rcyc[32];
  logic        prev_tck = 1'b0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mask(int n);
    if (n >= 32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic sb_t model(logic [1:0] op, int len,
                                logic [31:0] data,
                                logic [31:0] exp);
    sb_t e;
    int  n;
    n = (op == OP_RESET) ? 5 : ((len == 0) ? 1 : len);
    e.n = n;
    e.exp = exp;
    e.etms = '0;
    e.etdi = '0;
    e.acc = 0;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'd0: e.etms[i] = 1'b1;
        2'd1: e.etms[i] = data[i];
        2'd2: e.etdi[i] = data[i];
        default: begin
          e.etdi[i] = data[i];
          e.etms[i] = FLIP && (i == n - 1);
        end
      endcase
    end
    return e;
  endfunction

  task automatic sample();
    if (tck === 1'b1 && prev_tck === 1'b0) begin
      if (ri < 32) begin
        obs_tms[ri] = tms;
        obs_tdi[ri] = tdi;
        rcyc[ri] = cyc;
      end
      ri++;
      tdo = (ri < 32) ? cur_pat[ri] : 1'b0;
    end
    prev_tck = tck;
    if (bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp_valid", 1, 0);
      end else begin
        sb_t e;
        int  bad;
        e = sb.pop_front();
        bad = 0;
        for (int i = 0; i < e.n; i++)
          if (rcyc[i] != e.acc + D * (2 * i + 1)) bad++;
        chk("rsp_data", bus.rsp_data, e.exp);
        chk("rsp_cycle", cyc, e.acc + 2 * D * e.n);
        chk("tck_pulses", ri, e.n);
        chk("tms_seq", obs_tms & mask(e.n), e.etms);
        chk("tdi_seq", obs_tdi & mask(e.n), e.etdi);
        chk("rise_timing_errs", bad, 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sample();
  endtask

  task automatic issue(logic [1:0] op, int len, logic [31:0] data,
                       logic [31:0] pat, logic [31:0] exp,
                       output int acc);
    sb_t e;
    bit  ok;
    ok = 1'b0;
    acc = -1;
    bus.cmd_op = op;
    bus.cmd_len = LW'(len);
    bus.cmd_data = data;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
    end else begin
      tick();
      acc = cyc;
      ri = 0;
      cur_pat = pat;
      tdo = pat[0];
      obs_tms = '0;
      obs_tdi = '0;
      chk("cmd_ready_low_after_accept", bus.cmd_ready, 0);
      e = model(op, len, data, exp);
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    bus.cmd_valid = 1'b0;
    for (int t = 0; t < 400 && sb.size() != 0; t++) tick();
    if (sb.size() != 0) begin
      chk("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  vec_t vecs[8];

  initial begin
    int  a1, a2;
    sb_t m;
    vecs[0] = '{OP_RESET,     0, 32'hFFFFFFFF, 32'h15,       32'h15};
    vecs[1] = '{OP_SCAN,      4, 32'hA,        32'hB,        32'hB};
    vecs[2] = '{OP_SCAN_FLIP, 8, 32'hA5,       32'h3C,       32'h3C};
    vecs[3] = '{OP_TMS_SEQ,   6, 32'h1F,       32'h2A,       32'h2A};
    vecs[4] = '{OP_SCAN,      0, 32'h1,        32'hFFFFFFFF, 32'h1};
    vecs[5] = '{OP_SCAN,     32, 32'hDEADBEEF, 32'h12345678, 32'h12345678};
    vecs[6] = '{OP_SCAN,      3, 32'hFF,       32'hFF,       32'h7};
    vecs[7] = '{OP_SCAN_FLIP, 1, 32'h0,        32'h0,        32'h0};

    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_len = '0;
    bus.cmd_data = '0;

    rst_i = 1'b1;
    tick();
    tick();
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    rst_i = 1'b0;
    tick();
    chk("cmd_ready_after_reset", bus.cmd_ready, 1);
    chk("tms_after_reset", tms, 1);

    init_done = 1'b0;
    tick();
    tick();
    bus.cmd_op = OP_TMS_SEQ;
    bus.cmd_len = LW'(6);
    bus.cmd_data = 32'h1F;
    bus.cmd_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("cmd_ready_init_low", bus.cmd_ready, 0);
    chk("tck_init_low", tck, 0);
    init_done = 1'b1;
    tick();
    chk("cmd_ready_init_high", bus.cmd_ready, 1);
    issue(OP_TMS_SEQ, 6, 32'h1F, 32'h0, 32'h0, a1);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].len, vecs[i].data,
            vecs[i].pat, vecs[i].exp, a1);
      wait_idle();
      m = model(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].exp);
      chk("idle_tck", tck, 0);
      chk("idle_tms_hold", tms, m.etms[m.n-1]);
      chk("idle_tdi_hold", tdi, m.etdi[m.n-1]);
    end

    issue(OP_SCAN, 4, 32'h5, 32'h6, 32'h6, a1);
    issue(OP_TMS_SEQ, 3, 32'h5, 32'h1, 32'h1, a2);
    chk("b2b_accept_cycle", a2, a1 + 2 * D * 4 + 1);
    wait_idle();

    issue(OP_SCAN, 8, 32'hFF, 32'h0, 32'h0, a1);
    for (int t = 0; t < 100 && ri < 4; t++) tick();
    chk("reached_bit3", ri, 4);
    rst_i = 1'b1;
    tick();
    sb.delete();
    chk("midrst_tck", tck, 0);
    chk("midrst_tms", tms, 1);
    chk("midrst_tdi", tdi, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rsp_data", bus.rsp_data, 0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("cmd_ready_after_midrst", bus.cmd_ready, 1);
    issue(OP_SCAN, 5, 32'h13, 32'h19, 32'h19, a1);
    wait_idle();
    for (int t = 0; t < 30; t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
